// File: rtl/multiport_register_file.sv
// Register file: one write port, RD_PORTS registered read ports with write-first bypass, sequenced bulk clear.
// Latency: reads 1 cycle (rd_valid follows rd_en by one edge); bulk clear sweeps exactly DEPTH cycles.
// Backpressure: none on reads; writes and new clear requests are silently dropped while busy.
//
// Ports:
//   clk, rst       rising-edge clock, asynchronous active-low reset
//   wr_en/addr/dat single write port (wr_en, wr_addr, wr_data)
//   rd_en/rd_addr  per-port read strobe and packed addresses (port p at [p*ADDR_W +: ADDR_W])
//   rd_data        packed registered read data (port p at [p*DATA_W +: DATA_W])
//   rd_valid       per-port data-valid, one cycle after rd_en
//   clr_req/busy   start bulk clear / sweep in progress
//
// Build option: define ZERO_REG_EN to hard-wire entry 0 to zero.

module multiport_register_file #(
    parameter  int DATA_W   = 32,
    parameter  int DEPTH    = 32,
    parameter  int RD_PORTS = 2,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic [RD_PORTS-1:0]          rd_en,
    input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
    output logic [RD_PORTS*DATA_W-1:0]   rd_data,
    output logic [RD_PORTS-1:0]          rd_valid,
    input  logic                         clr_req,
    output logic                         busy
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    // One extra bit so the range check also works when DEPTH is a power of two.
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    logic [0:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_ok;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_X);
    endfunction

    // A write only lands in IDLE with no clear starting on the same edge.
    always_comb begin
        wr_ok = wr_en && (state == ST_IDLE) && !clr_req && in_range(wr_addr);
`ifdef ZERO_REG_EN
        if (wr_addr == '0) begin
            wr_ok = 1'b0;
        end
`endif
    end

    // Clear sequencer: ptr walks 0..DEPTH-1, one entry per cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            ptr   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clr_req) begin
                        state <= ST_CLEAR;
                        ptr   <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (ptr == LAST) begin
                        state <= ST_IDLE;
                        ptr   <= '0;
                    end else begin
                        ptr <= ptr + ADDR_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    ptr   <= '0;
                end
            endcase
        end
    end

    // busy decodes a register only, so there is no input-to-output path.
    assign busy = (state == ST_CLEAR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (state == ST_CLEAR) begin
            mem[ptr] <= '0;
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] nxt;
        logic [DATA_W-1:0] rq;

        assign ra = rd_addr[p*ADDR_W +: ADDR_W];

        // Write-first: an accepted same-cycle write to the read address is forwarded.
        // Reads during a sweep see the array before this edge's clear.
        always_comb begin
            nxt = '0;
            if (!in_range(ra)) begin
                nxt = '0;
            end else if (wr_ok && (ra == wr_addr)) begin
                nxt = wr_data;
            end else begin
                nxt = mem[ra];
            end
`ifdef ZERO_REG_EN
            if (ra == '0) begin
                nxt = '0;
            end
`endif
        end

        // Data holds its last value when the port is idle.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                rq <= '0;
            end else if (rd_en[p]) begin
                rq <= nxt;
            end
        end

        assign rd_data[p*DATA_W +: DATA_W] = rq;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid <= '0;
        end else begin
            rd_valid <= rd_en;
        end
    end

endmodule

// File: tb/tb_multiport_register_file.sv
module tb_multiport_register_file;

    localparam int AW = 5;

`ifdef ZERO_REG_EN
    localparam logic [31:0] ZEXP = 32'h0000_0000;
`else
    localparam logic [31:0] ZEXP = 32'hFFFF_FFFF;
`endif

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [1:0]  rd_en;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_valid;
    logic        clr_req;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt;

    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];

    multiport_register_file dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .clr_req  (clr_req),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_en   = '0;
        rd_addr = '0;
        clr_req = 1'b0;
    endtask

    // Advance one edge, then return inputs to idle.
    task automatic cyc();
        @(posedge clk);
        #1;
        drive_idle();
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = 5'(a);
        wr_data = d;
    endtask

    task automatic rd(input int p, input int a, input logic [31:0] e);
        rd_en[p] = 1'b1;
        rd_addr[p*AW +: AW] = 5'(a);
        if (p == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endtask

    // Monitor: every presented read result is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (rd_valid[0] === 1'b1) begin
                if (exp_q0.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL port0 unexpected rd_valid: data %h, no read pending", rd_data[31:0]);
                end else begin
                    check("port0 rd_data", {32'h0, rd_data[31:0]}, {32'h0, exp_q0.pop_front()});
                end
            end
            if (rd_valid[1] === 1'b1) begin
                if (exp_q1.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL port1 unexpected rd_valid: data %h, no read pending", rd_data[63:32]);
                end else begin
                    check("port1 rd_data", {32'h0, rd_data[63:32]}, {32'h0, exp_q1.pop_front()});
                end
            end
        end
    end

    initial begin
        drive_idle();
        rst = 1'b1;

        // Reset asserted mid-cycle takes effect immediately.
        #12 rst = 1'b0;
        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset rd_valid", 64'(rd_valid), 64'd0);
        check("reset rd_data", rd_data, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        cyc();
        check("post-release rd_valid", 64'(rd_valid), 64'd0);
        check("post-release busy", 64'(busy), 64'd0);

        // Read of an untouched entry.
        rd(0, 7, 32'h0000_0000);
        cyc();

        // Write then read on both ports.
        wr(5, 32'hDEAD_BEEF);
        cyc();
        rd(0, 5, 32'hDEAD_BEEF);
        rd(1, 5, 32'hDEAD_BEEF);
        cyc();
        check("rd_valid both ports", 64'(rd_valid), 64'd3);

        // Write-first bypass on both ports simultaneously.
        wr(9, 32'h1234_5678);
        rd(1, 9, 32'h1234_5678);
        rd(0, 9, 32'h1234_5678);
        cyc();
        cyc();
        check("idle rd_valid low", 64'(rd_valid), 64'd0);
        check("idle rd_data holds", {32'h0, rd_data[63:32]}, 64'h1234_5678);

        // Fill every entry with nonzero data.
        for (int i = 0; i < 32; i++) begin
            wr(i, 32'hA500_0000 + 32'(i));
            cyc();
        end
        rd(0, 31, 32'hA500_001F);
        rd(1, 3,  32'hA500_0003);
        cyc();

        // Clear wins over a simultaneous write.
        clr_req = 1'b1;
        wr(3, 32'h0BAD_0003);
        cyc();
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            if (busy !== 1'b1) break;
            cnt++;
            if (k == 0) wr(3, 32'h0BAD_0013);
            if (k == 5) begin
                rd(0, 31, 32'hA500_001F);
                rd(1, 0,  32'h0000_0000);
            end
            if (k == 10) clr_req = 1'b1;
            cyc();
        end
        check("busy cycles", 64'(cnt), 64'd32);
        cyc();
        check("busy low after sweep", 64'(busy), 64'd0);

        for (int i = 0; i < 16; i++) begin
            rd(0, i,      32'h0000_0000);
            rd(1, i + 16, 32'h0000_0000);
            cyc();
        end

        // Reset in the middle of a sweep.
        wr(25, 32'h2525_2525);
        cyc();
        clr_req = 1'b1;
        cyc();
        repeat (10) cyc();
        #3 rst = 1'b0;
        #1;
        check("mid-sweep reset busy", 64'(busy), 64'd0);
        check("mid-sweep reset rd_valid", 64'(rd_valid), 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        wr(20, 32'hCAFE_F00D);
        cyc();
        rd(0, 20, 32'hCAFE_F00D);
        rd(1, 25, 32'h0000_0000);
        cyc();
        check("busy after reset release", 64'(busy), 64'd0);

        // Entry 0 behaviour (hard-wired zero only with ZERO_REG_EN).
        wr(0, 32'hFFFF_FFFF);
        rd(0, 0, ZEXP);
        cyc();
        rd(1, 0, ZEXP);
        cyc();

        cyc();
        cyc();
        check("port0 scoreboard drained", 64'(exp_q0.size()), 64'd0);
        check("port1 scoreboard drained", 64'(exp_q1.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multiport_register_file.md
Name: multiport_register_file

Overview:
- Parametrised successor to the single-port register file: one write port, RD_PORTS independent read ports, registered reads, write-to-read bypass.
- Adds a sequenced bulk-clear engine with a busy indication.
- Sits inside the cpu top beside control_unit and alu. Replaces the fixed register file; instance name stays "registers".

Parameters:
DATA_W, 32, width of each entry in bits
DEPTH, 32, number of entries (2..256, need not be a power of 2)
RD_PORTS, 2, number of read ports (1..4)
ADDR_W, $clog2(DEPTH), address width; derived, not overridden

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-low reset
wr_en  input  1  write strobe
wr_addr  input  ADDR_W  write address
wr_data  input  DATA_W  write data
rd_en  input  RD_PORTS  per-port read strobe
rd_addr  input  RD_PORTS*ADDR_W  packed read addresses; port p at [p*ADDR_W +: ADDR_W]
rd_data  output  RD_PORTS*DATA_W  packed registered read data
rd_valid  output  RD_PORTS  per-port data-valid, one cycle after rd_en
clr_req  input  1  start bulk clear
busy  output  1  high while clear sweep in progress

Behaviour:
- Reset (rst low, asynchronous): all entries = 0; rd_data = 0; rd_valid = 0; busy = 0; FSM = IDLE; sweep pointer = 0. Releasing reset takes effect on the next rising clk edge.
- Write: when wr_en = 1 and the FSM is IDLE, entry[wr_addr] <= wr_data at the edge.
  - wr_addr >= DEPTH: write dropped.
- Read: latency 1 cycle per port.
  - rd_en[p] = 1 at edge N: rd_valid[p] = 1 and rd_data[p] valid after edge N.
  - rd_en[p] = 0: rd_valid[p] = 0 and rd_data[p] holds its last value.
  - rd_addr >= DEPTH: returns 0 with rd_valid = 1.
- Bypass (write-first): same-cycle wr_en with rd_addr[p] == wr_addr, write accepted → rd_data[p] = wr_data. Applies to all ports simultaneously.
- Multiple read ports may access the same address in the same cycle; all return the identical value.
- FSM states:
  - IDLE: clr_req = 1 → CLEAR; pointer = 0; busy = 1 from the next cycle.
  - CLEAR: entry[pointer] <= 0 each cycle; pointer increments; when pointer == DEPTH-1 is cleared → IDLE, busy = 0 the following cycle.
  - Sweep length is exactly DEPTH cycles.
- Simultaneous clr_req and wr_en in IDLE: clear wins, write dropped.
- clr_req while busy: ignored; the sweep does not restart.
- wr_en while busy: dropped, no error flag.
- rd_en while busy: accepted. Returns current array contents; already-swept entries read 0.
- Reset mid-sweep: sweep aborts, array zeroed by reset, busy = 0.
- No combinational path from any input to any output.

Optional Feature:
ZERO_REG_EN
- Defined: entry 0 is hard-wired zero.
  - Writes to address 0 are dropped.
  - Reads of address 0 return 0.
  - Bypass never applies to address 0.
  - The clear sweep still runs DEPTH cycles.
- Undefined: entry 0 is an ordinary storage location.

Test Plan:
- Reset: assert rst = 0 mid-cycle, release → rd_data = 0, rd_valid = 0, busy = 0. Read addr 7 → 0x00000000.
- Write then read: write 0xDEADBEEF to addr 5. Next cycle read addr 5 on ports 0 and 1 → both rd_data = 0xDEADBEEF, rd_valid = 2'b11 one cycle later.
- Bypass: wr_en to addr 9 with 0x12345678, same cycle rd_en port 1 addr 9 → next cycle rd_data[1] = 0x12345678.
- Bulk clear: fill all 32 entries with nonzero data, pulse clr_req → busy high exactly 32 cycles. A concurrent wr_en to addr 3 is dropped. All entries read 0 afterwards.
- Reset mid-sweep: pulse clr_req, assert rst at sweep cycle 10 → busy = 0 immediately. After release, a write to addr 20 succeeds on the first IDLE cycle.
- ZERO_REG_EN defined: write 0xFFFFFFFF to addr 0, read addr 0 (same cycle and next cycle) → 0. Undefined: same sequence → 0xFFFFFFFF.
